// File: rtl/forward_check_pipe_if.sv
// Operand-forwarding check bus: source query, bypass broadcast and the registered operand result.
interface forward_check_pipe_if #(
    parameter int unsigned NUM_BYPASS        = 6,
    parameter int unsigned SIZE_PHYSICAL_LOG = 7,
    parameter int unsigned SIZE_DATA         = 32
);
    logic                                    flush_i;
    logic                                    stall_i;
    logic                                    valid_i;
    logic [SIZE_PHYSICAL_LOG-1:0]            srcReg_i;
    logic [SIZE_DATA-1:0]                    srcData_i;
    logic [NUM_BYPASS-1:0]                   bypassValid_i;
    logic [NUM_BYPASS*SIZE_PHYSICAL_LOG-1:0] bypassTag_i;
    logic [NUM_BYPASS*SIZE_DATA-1:0]         bypassData_i;
    logic                                    valid_o;
    logic [SIZE_DATA-1:0]                    dataOut_o;
    logic                                    hit_o;
    logic                                    multiHit_o;

    modport master (
        output flush_i, stall_i, valid_i, srcReg_i, srcData_i,
               bypassValid_i, bypassTag_i, bypassData_i,
        input  valid_o, dataOut_o, hit_o, multiHit_o
    );

    modport slave (
        input  flush_i, stall_i, valid_i, srcReg_i, srcData_i,
               bypassValid_i, bypassTag_i, bypassData_i,
        output valid_o, dataOut_o, hit_o, multiHit_o
    );
endinterface

// File: rtl/forward_check_pipe.sv
// Pipelined operand bypass check: live bus plus DEPTH cycles of broadcast history,
// newest stage wins, lowest channel wins within a stage; result registered for the FU.
module forward_check_pipe #(
    parameter int unsigned NUM_BYPASS        = 6,
    parameter int unsigned DEPTH             = 2,
    parameter int unsigned SIZE_PHYSICAL_LOG = 7,
    parameter int unsigned SIZE_DATA         = 32
) (
    input logic                  clk,
    input logic                  reset,
    forward_check_pipe_if.slave  bus
);
    localparam int unsigned NB = NUM_BYPASS;
    localparam int unsigned TW = SIZE_PHYSICAL_LOG;
    localparam int unsigned DW = SIZE_DATA;
    localparam int unsigned HD = (DEPTH == 0) ? 1 : DEPTH;

    logic [TW-1:0] live_tag  [NB];
    logic [DW-1:0] live_data [NB];

    logic [NB-1:0] hist_valid_q [HD];
    logic [TW-1:0] hist_tag_q   [HD][NB];
    logic [DW-1:0] hist_data_q  [HD][NB];

    logic          sel_hit_c;
    logic          sel_multi_c;
    logic [DW-1:0] sel_data_c;

    logic          valid_q, valid_d;
    logic          hit_q, hit_d;
    logic          multi_q, multi_d;
    logic [DW-1:0] data_q, data_d;

    // Unpack the live bus, channel 0 in the LSBs.
    always_comb begin
        for (int k = 0; k < int'(NB); k++) begin
            live_tag[k]  = bus.bypassTag_i[k*TW +: TW];
            live_data[k] = bus.bypassData_i[k*DW +: DW];
        end
    end

    if (DEPTH > 0) begin : g_hist
        logic [NB-1:0] hist_valid_d [HD];
        logic [TW-1:0] hist_tag_d   [HD][NB];
        logic [DW-1:0] hist_data_d  [HD][NB];

        // Shift every cycle regardless of stall; this tracks register-file write timing.
        always_comb begin
            hist_valid_d[0] = bus.flush_i ? '0 : bus.bypassValid_i;
            hist_tag_d[0]   = live_tag;
            hist_data_d[0]  = live_data;
            for (int j = 1; j < int'(HD); j++) begin
                hist_valid_d[j] = bus.flush_i ? '0 : hist_valid_q[j-1];
                hist_tag_d[j]   = hist_tag_q[j-1];
                hist_data_d[j]  = hist_data_q[j-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < int'(HD); j++) hist_valid_q[j] <= '0;
            end else begin
                hist_valid_q <= hist_valid_d;
            end
        end

        always_ff @(posedge clk) begin
            hist_tag_q  <= hist_tag_d;
            hist_data_q <= hist_data_d;
        end
    end else begin : g_no_hist
        always_comb begin
            for (int j = 0; j < int'(HD); j++) begin
                hist_valid_q[j] = '0;
                for (int k = 0; k < int'(NB); k++) begin
                    hist_tag_q[j][k]  = '0;
                    hist_data_q[j][k] = '0;
                end
            end
        end
    end

    // Oldest stage evaluated first so newer matching stages overwrite it.
    always_comb begin
        logic [NB-1:0] m;
        m           = '0;
        sel_data_c  = bus.srcData_i;
        sel_hit_c   = 1'b0;
        sel_multi_c = 1'b0;
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            for (int k = 0; k < int'(NB); k++)
                m[k] = hist_valid_q[s][k] && (hist_tag_q[s][k] == bus.srcReg_i);
            if (m != '0) begin
                sel_hit_c   = 1'b1;
                sel_multi_c = (m & (m - NB'(1))) != '0;
                for (int k = int'(NB) - 1; k >= 0; k--)
                    if (m[k]) sel_data_c = hist_data_q[s][k];
            end
        end
        for (int k = 0; k < int'(NB); k++)
            m[k] = bus.bypassValid_i[k] && (live_tag[k] == bus.srcReg_i);
        if (m != '0) begin
            sel_hit_c   = 1'b1;
            sel_multi_c = (m & (m - NB'(1))) != '0;
            for (int k = int'(NB) - 1; k >= 0; k--)
                if (m[k]) sel_data_c = live_data[k];
        end
    end

    always_comb begin
        valid_d = valid_q;
        hit_d   = hit_q;
        multi_d = multi_q;
        data_d  = data_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
            hit_d   = 1'b0;
            multi_d = 1'b0;
        end else if (!bus.stall_i) begin
            valid_d = bus.valid_i;
            data_d  = sel_data_c;
            hit_d   = sel_hit_c && bus.valid_i;
            multi_d = sel_multi_c && bus.valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
            multi_q <= multi_d;
            data_q  <= data_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.dataOut_o  = data_q;
    assign bus.hit_o      = hit_q;
    assign bus.multiHit_o = multi_q;
endmodule

// File: tb/tb_forward_check_pipe.sv
// Bench for forward_check_pipe: directed vectors, a cycle-log reference model and literal spot checks.
module tb_forward_check_pipe;
    localparam int NB    = 6;
    localparam int DEPTH = 2;
    localparam int TW    = 7;
    localparam int DW    = 32;
    localparam int MAXC  = 512;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    forward_check_pipe_if #(.NUM_BYPASS(NB), .SIZE_PHYSICAL_LOG(TW), .SIZE_DATA(DW)) bus ();

    forward_check_pipe #(
        .NUM_BYPASS(NB), .DEPTH(DEPTH), .SIZE_PHYSICAL_LOG(TW), .SIZE_DATA(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a log of every cycle's bus. A broadcast from cycle c is visible
    // at cycle n when n-c <= DEPTH and no flush/reset happened in cycles c..n-1.
    logic [NB-1:0] rec_v [MAXC];
    logic [TW-1:0] rec_t [MAXC][NB];
    logic [DW-1:0] rec_d [MAXC][NB];
    int            cyc        = 0;
    int            last_clear = -1;
    int            c, cnt, first;
    logic          m_found, m_multi;
    logic [DW-1:0] m_data;
    logic          model_ok = 1'b0;
    logic          exp_v, exp_h, exp_m;
    logic [DW-1:0] exp_d;

    always @(posedge clk) begin
        rec_v[cyc % MAXC] = bus.bypassValid_i;
        for (int k = 0; k < NB; k++) begin
            rec_t[cyc % MAXC][k] = bus.bypassTag_i[k*TW +: TW];
            rec_d[cyc % MAXC][k] = bus.bypassData_i[k*DW +: DW];
        end
        m_found = 1'b0;
        m_multi = 1'b0;
        m_data  = bus.srcData_i;
        for (int a = 0; a <= DEPTH; a++) begin
            c = cyc - a;
            if (!m_found && c >= 0 && (a == 0 || c > last_clear)) begin
                cnt   = 0;
                first = -1;
                for (int k = 0; k < NB; k++) begin
                    if (rec_v[c % MAXC][k] && rec_t[c % MAXC][k] == bus.srcReg_i) begin
                        cnt++;
                        if (first < 0) first = k;
                    end
                end
                if (cnt > 0) begin
                    m_found = 1'b1;
                    m_multi = (cnt > 1);
                    m_data  = rec_d[c % MAXC][first];
                end
            end
        end
        if (reset) begin
            exp_v = 1'b0; exp_d = '0; exp_h = 1'b0; exp_m = 1'b0;
            model_ok = 1'b1;
        end else if (bus.flush_i) begin
            exp_v = 1'b0; exp_h = 1'b0; exp_m = 1'b0;
        end else if (!bus.stall_i) begin
            exp_v = bus.valid_i;
            exp_d = m_data;
            exp_h = m_found && bus.valid_i;
            exp_m = m_multi && bus.valid_i;
        end
        if (reset || bus.flush_i) last_clear = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            vectors++;
            if (bus.valid_o !== exp_v || bus.dataOut_o !== exp_d ||
                bus.hit_o !== exp_h || bus.multiHit_o !== exp_m) begin
                miscompares++;
                $display("FAIL model cyc=%0d: got v=%0b d=%h h=%0b m=%0b, want v=%0b d=%h h=%0b m=%0b",
                         cyc, bus.valid_o, bus.dataOut_o, bus.hit_o, bus.multiHit_o,
                         exp_v, exp_d, exp_h, exp_m);
            end
        end
    end

    task automatic check_lit(input string name, input logic v, input logic [DW-1:0] d,
                             input logic h, input logic m);
        vectors++;
        if (bus.valid_o !== v || bus.dataOut_o !== d || bus.hit_o !== h || bus.multiHit_o !== m) begin
            miscompares++;
            $display("FAIL %s: got v=%0b d=%h h=%0b m=%0b, want v=%0b d=%h h=%0b m=%0b",
                     name, bus.valid_o, bus.dataOut_o, bus.hit_o, bus.multiHit_o, v, d, h, m);
        end
    endtask

    task automatic idle_bus();
        bus.bypassValid_i = '0;
        bus.bypassTag_i   = '0;
        bus.bypassData_i  = '0;
    endtask

    task automatic set_ch(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.bypassValid_i[k]         = 1'b1;
        bus.bypassTag_i[k*TW +: TW]  = t;
        bus.bypassData_i[k*DW +: DW] = d;
    endtask

    task automatic query(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.valid_i   = v;
        bus.srcReg_i  = t;
        bus.srcData_i = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_bus();
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        idle_bus();
        query(1'b0, '0, '0);
        tick(); tick();
        check_lit("reset_state", 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Live hit
        set_ch(3, 7'h12, 32'hDEADBEEF); query(1'b1, 7'h12, 32'h0); tick();
        check_lit("live_hit", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);

        // History hit in H1, then aged out
        set_ch(1, 7'h05, 32'h11); query(1'b0, 7'h7F, 32'h0); tick();
        query(1'b0, 7'h7F, 32'h0); tick();
        query(1'b1, 7'h05, 32'hAA); tick();
        check_lit("hist_hit_h1", 1'b1, 32'h11, 1'b1, 1'b0);
        query(1'b1, 7'h05, 32'hAA); tick();
        check_lit("hist_aged_out", 1'b1, 32'hAA, 1'b0, 1'b0);

        // Stage and channel priority
        set_ch(2, 7'h20, 32'h1); query(1'b0, 7'h00, 32'h0); tick();
        tick();
        set_ch(5, 7'h20, 32'h2); query(1'b1, 7'h20, 32'h99); tick();
        check_lit("live_over_hist", 1'b1, 32'h2, 1'b1, 1'b0);
        set_ch(0, 7'h20, 32'h3); set_ch(4, 7'h20, 32'h4); query(1'b1, 7'h20, 32'h99); tick();
        check_lit("multi_low_chan", 1'b1, 32'h3, 1'b1, 1'b1);
        set_ch(1, 7'h20, 32'h5); query(1'b1, 7'h20, 32'h99); tick();
        check_lit("older_multi_ignored", 1'b1, 32'h5, 1'b1, 1'b0);

        // Flush
        set_ch(0, 7'h30, 32'h123); query(1'b1, 7'h01, 32'h44); tick();
        check_lit("pre_flush", 1'b1, 32'h44, 1'b0, 1'b0);
        bus.flush_i = 1'b1; query(1'b1, 7'h30, 32'h66); tick();
        check_lit("flush_out", 1'b0, 32'h44, 1'b0, 1'b0);
        query(1'b1, 7'h30, 32'h77); tick();
        check_lit("post_flush_miss", 1'b1, 32'h77, 1'b0, 1'b0);

        // Stall holds outputs while history keeps shifting
        query(1'b1, 7'h40, 32'h55); tick();
        bus.stall_i = 1'b1; set_ch(2, 7'h41, 32'hBB); query(1'b1, 7'h41, 32'h0); tick();
        check_lit("stall_1", 1'b1, 32'h55, 1'b0, 1'b0);
        bus.stall_i = 1'b1; set_ch(3, 7'h42, 32'hCC); query(1'b1, 7'h41, 32'h0); tick();
        check_lit("stall_2", 1'b1, 32'h55, 1'b0, 1'b0);
        bus.stall_i = 1'b1; query(1'b1, 7'h42, 32'h0); tick();
        check_lit("stall_3", 1'b1, 32'h55, 1'b0, 1'b0);
        query(1'b1, 7'h42, 32'h0); tick();
        check_lit("stall_bcast_in_h1", 1'b1, 32'hCC, 1'b1, 1'b0);
        query(1'b1, 7'h42, 32'hEE); tick();
        check_lit("stall_bcast_aged", 1'b1, 32'hEE, 1'b0, 1'b0);

        // Reset mid-operation
        set_ch(0, 7'h50, 32'h500); query(1'b1, 7'h50, 32'h0); tick();
        set_ch(1, 7'h51, 32'h510); query(1'b1, 7'h51, 32'h0); tick();
        reset = 1'b1; set_ch(2, 7'h52, 32'h520); query(1'b1, 7'h50, 32'h0); tick();
        reset = 1'b0;
        check_lit("midrun_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        query(1'b1, 7'h51, 32'h66); tick();
        check_lit("post_reset_miss", 1'b1, 32'h66, 1'b0, 1'b0);
        query(1'b1, 7'h52, 32'h67); tick();
        check_lit("reset_cycle_not_captured", 1'b1, 32'h67, 1'b0, 1'b0);

        // valid_i low still updates data
        set_ch(4, 7'h60, 32'h6060); query(1'b0, 7'h60, 32'h1); tick();
        check_lit("valid_low", 1'b0, 32'h6060, 1'b0, 1'b0);
        // Tag 0 is ordinary
        set_ch(0, 7'h00, 32'hF00); query(1'b1, 7'h00, 32'h1); tick();
        check_lit("tag_zero", 1'b1, 32'hF00, 1'b1, 1'b0);
        // Matching tag on an invalid channel
        set_ch(1, 7'h70, 32'h1); bus.bypassValid_i[1] = 1'b0; query(1'b1, 7'h70, 32'h2); tick();
        check_lit("chan_invalid", 1'b1, 32'h2, 1'b0, 1'b0);
        // Flush beats stall
        bus.flush_i = 1'b1; bus.stall_i = 1'b1; set_ch(0, 7'h09, 32'h99); query(1'b1, 7'h09, 32'h0); tick();
        check_lit("flush_over_stall", 1'b0, 32'h2, 1'b0, 1'b0);
        query(1'b1, 7'h09, 32'h3); tick();
        check_lit("flush_stall_not_captured", 1'b1, 32'h3, 1'b0, 1'b0);
        // Reset with flush
        set_ch(2, 7'h0A, 32'hA0); query(1'b1, 7'h0A, 32'h4); tick();
        reset = 1'b1; bus.flush_i = 1'b1; set_ch(0, 7'h0B, 32'hB0); query(1'b1, 7'h0B, 32'h5); tick();
        reset = 1'b0;
        check_lit("reset_and_flush", 1'b0, 32'h0, 1'b0, 1'b0);
        query(1'b1, 7'h0A, 32'h6); tick();
        check_lit("reset_flush_hist_clear", 1'b1, 32'h6, 1'b0, 1'b0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/forward_check_pipe.md
Name: forward_check_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle operand bypass check in the execute stage.
- Compares a source physical tag against the live bypass bus and against a history buffer holding the last DEPTH cycles of broadcasts. This covers results that have left the bypass bus but are not yet readable from the physical register file.
- Selects the newest matching value, otherwise the register-file data, and registers the operand for the functional unit.
- Also flags illegal multiple hits within one stage.

Parameters:
- NUM_BYPASS, 6, number of bypass channels per cycle.
- DEPTH, 2, history stages retained (register-file write-to-read gap). Legal range 0..4; 0 means live bus only.
- SIZE_PHYSICAL_LOG, 7, physical tag width.
- SIZE_DATA, 32, operand width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- flush_i, in, 1, pipeline flush (mispredict/exception recovery).
- stall_i, in, 1, hold output register.
- valid_i, in, 1, srcReg_i/srcData_i carry a real operand this cycle.
- srcReg_i, in, SIZE_PHYSICAL_LOG, source physical tag.
- srcData_i, in, SIZE_DATA, register-file read data for srcReg_i.
- bypassValid_i, in, NUM_BYPASS, per-channel broadcast valid.
- bypassTag_i, in, NUM_BYPASS*SIZE_PHYSICAL_LOG, packed tags; channel k occupies bits [k*W+W-1:k*W].
- bypassData_i, in, NUM_BYPASS*SIZE_DATA, packed data, same packing.
- valid_o, out, 1, registered operand valid.
- dataOut_o, out, SIZE_DATA, registered selected operand.
- hit_o, out, 1, registered: operand came from bus or history, not from srcData_i.
- multiHit_o, out, 1, registered: more than one channel matched inside the winning stage.

Behaviour:
- History buffer:
  - H[0..DEPTH-1] each hold NUM_BYPASS {valid, tag, data}.
  - Every cycle (stall_i ignored), H[0] <= live bus and H[j] <= H[j-1]. The oldest entry is discarded.
  - Shifting is independent of stall because it tracks register-file write timing, not consumer progress.
- Match:
  - match[s][k] = entry valid && tag == srcReg_i. Stage s = L (live bus), H0 … H(DEPTH-1).
  - Stage priority: L > H0 > H1 > … (newest wins).
  - Within the winning stage, the lowest channel index wins.
  - multiHit is asserted if the winning stage has ≥2 matches. Matches in older stages never set multiHit.
  - No match in any stage: select srcData_i, hit = 0.
- Output register, first matching condition applies:
  - reset: valid_o = 0, dataOut_o = 0, hit_o = 0, multiHit_o = 0; all history valids = 0.
  - flush_i: valid_o = 0, hit_o = 0, multiHit_o = 0, dataOut_o holds. All history valids cleared; this cycle's live bus is not captured. Next cycle H0 is empty.
  - stall_i: all outputs hold.
  - otherwise: valid_o <= valid_i, dataOut_o <= selected value, hit_o <= hit && valid_i, multiHit_o <= multiHit && valid_i.
- Latency: 1 cycle from srcReg_i/bus to dataOut_o. The match path is purely combinational from inputs and H into the output register.
- valid_i = 0: the selection is still computed and dataOut_o still updates, but valid_o, hit_o and multiHit_o are 0.
- Reset and flush in the same cycle: reset wins, with identical history effect.
- Flush and stall in the same cycle: flush wins.
- DEPTH = 0: no history registers are generated; behaviour equals a registered live-bus check.
- Tag 0 is an ordinary tag, with no special casing.
- Packed channel ordering is fixed LSB = channel 0.

Test Plan:
- Live hit: srcReg = 0x12, channel 3 valid, tag 0x12, data 0xDEADBEEF → next cycle dataOut_o = 0xDEADBEEF, hit_o = 1, valid_o = 1.
- History hit: cycle t, channel 1 broadcasts tag 0x05, data 0x11. Cycle t+2, srcReg = 0x05, bus idle, srcData = 0xAA (DEPTH = 2, entry in H1) → t+3 dataOut_o = 0x11, hit_o = 1. At cycle t+3 with the same query → t+4 dataOut_o = 0xAA, hit_o = 0 (aged out).
- Priority: tag 0x20 in H1 with data 0x1, and in live channel 5 with data 0x2 → dataOut_o = 0x2, multiHit_o = 0. With live channels 0 and 4 both tagged 0x20 (data 0x3, 0x4) → dataOut_o = 0x3, multiHit_o = 1.
- Flush: broadcast tag 0x30 at t, flush_i at t+1, query 0x30 at t+2 with srcData = 0x77 → valid_o = 0 at t+2; t+3 dataOut_o = 0x77, hit_o = 0.
- Stall: dataOut_o = 0x55 latched, stall_i held 3 cycles while the bus changes → outputs stay 0x55. History still shifts, so a broadcast made during the stall is matchable up to DEPTH cycles later.
- Reset mid-operation: history full, reset for one cycle → all outputs 0. A query on the following cycle for any previously broadcast tag returns srcData_i with hit_o = 0.
